// File: rtl/icache_responder.sv
// icache_responder: direct-mapped I-cache with combinational lookup and word-by-word req/ack line refill
module icache_responder #(
  parameter int LINES = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] Icache_bus_in,
  output logic [32:0] Icache_bus_out,
  input  logic        Inv,
  output logic        Mem_Req,
  output logic [31:0] Mem_Addr,
  input  logic [31:0] Mem_Data,
  input  logic        Mem_Ack,
  output logic [31:0] Miss_Count
);
  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(LINES);
  localparam int TW = 30 - WB - IB;
  typedef enum logic {IDLE, REFILL} state_t;
  state_t state_q, state_d;
  logic mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d, miss_count_q, miss_count_d;
  logic [WB-1:0] cnt_q, cnt_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [31:0] data_mem_q [LINES][WORDS_PER_LINE];
  logic [TW-1:0] tag_mem_q [LINES];
  logic [WB-1:0] word;
  logic [IB-1:0] idx, r_idx;
  logic [TW-1:0] tag, r_tag;
  logic hit, last_ack, unused_ok;
  assign word = Icache_bus_in[2+:WB];
  assign idx = Icache_bus_in[2+WB+:IB];
  assign tag = Icache_bus_in[31-:TW];
  // the refill address keeps the line's index and tag bits fixed for the whole refill
  assign r_idx = mem_addr_q[2+WB+:IB];
  assign r_tag = mem_addr_q[31-:TW];
  assign hit = state_q == IDLE && valid_q[idx] && tag_mem_q[idx] == tag;
  assign last_ack = state_q == REFILL && Mem_Ack && cnt_q == WB'(WORDS_PER_LINE - 1);
  assign Icache_bus_out = {!hit, data_mem_q[idx][word]};
  assign Mem_Req = mem_req_q;
  assign Mem_Addr = mem_addr_q;
  assign Miss_Count = miss_count_q;
  assign unused_ok = ^Icache_bus_in[1:0];
  // next state: start a refill on an idle miss, advance one word per ack, validate on the last
  always_comb begin
    state_d = state_q;
    mem_req_d = mem_req_q;
    mem_addr_d = mem_addr_q;
    cnt_d = cnt_q;
    miss_count_d = miss_count_q;
    valid_d = Inv ? '0 : valid_q;
    if (state_q == IDLE && !hit) begin
      state_d = REFILL;
      mem_req_d = 1'b1;
      mem_addr_d = {Icache_bus_in[31:2+WB], {(2+WB){1'b0}}};
      cnt_d = '0;
      miss_count_d = miss_count_q + 32'd1;
    end else if (last_ack) begin
      valid_d[r_idx] = 1'b1;
      mem_req_d = 1'b0;
      state_d = IDLE;
    end else if (state_q == REFILL && Mem_Ack) begin
      cnt_d = cnt_q + WB'(1);
      mem_addr_d = mem_addr_q + 32'd4;
    end
  end
  // control registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      mem_req_q <= 1'b0;
      mem_addr_q <= '0;
      cnt_q <= '0;
      miss_count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cnt_q <= cnt_d;
      miss_count_q <= miss_count_d;
      valid_q <= valid_d;
    end
  end
  // data and tag arrays are write-only on refill acks and are never reset
  always_ff @(posedge Clk) begin
    if (!Rst && state_q == REFILL && Mem_Ack) data_mem_q[r_idx][cnt_q] <= Mem_Data;
    if (!Rst && last_ack) tag_mem_q[r_idx] <= r_tag;
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: vector table, directed refill scenarios and random traffic against a line-level model
module tb_icache_responder;
  localparam int LINES = 16;
  localparam int W = 4;
  logic Clk = 0, Rst = 1, Inv = 0, Mem_Ack = 0, Mem_Req;
  logic [31:0] addr = 0, Mem_Data = 0, Mem_Addr, Miss_Count;
  logic [32:0] bus_out;
  int checks = 0, failures = 0;
  bit m_init = 0, busy = 0;
  bit [LINES-1:0] m_v;
  logic [31:0] m_b [LINES];
  logic [31:0] m_base, m_maddr, m_mc;
  int m_acks;

  typedef struct {
    logic rst; logic [31:0] addr; logic ack; logic chk;
    logic imiss; logic req; logic [31:0] maddr; logic [31:0] mc; logic [31:0] data; logic dchk;
  } vec_t;
  vec_t v [8];

  always #5 Clk = ~Clk;

  icache_responder #(.LINES(LINES), .WORDS_PER_LINE(W)) dut (
    .Clk(Clk), .Rst(Rst), .Icache_bus_in(addr), .Icache_bus_out(bus_out), .Inv(Inv),
    .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data), .Mem_Ack(Mem_Ack),
    .Miss_Count(Miss_Count));

  // instruction memory contents: the 0x100 line holds 0xA0..0xA3, every other word is ~address
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a[31:4] == 28'h10) ? 32'hA0 + {30'd0, a[3:2]} : ~a;
  endfunction
  function automatic logic [31:0] lbase(input logic [31:0] a);
    return a & ~32'(W * 4 - 1);
  endfunction
  function automatic int li(input logic [31:0] a);
    return int'((a / (W * 4)) % LINES);
  endfunction
  function automatic bit model_miss(input logic [31:0] a);
    return busy || !(m_v[li(a)] && m_b[li(a)] == lbase(a));
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // one clock: drive inputs, compare against the model, then advance the model past the edge
  task automatic tick(input logic rst, input logic [31:0] a, input logic inv, input logic ack);
    bit em;
    @(negedge Clk);
    Rst = rst; addr = a; Inv = inv; Mem_Ack = ack; Mem_Data = data_of(Mem_Addr);
    #1;
    em = model_miss(a);
    if (m_init) begin
      chk("imiss", {31'd0, bus_out[32]}, {31'd0, em});
      chk("mem_req", {31'd0, Mem_Req}, {31'd0, busy});
      chk("mem_addr", Mem_Addr, m_maddr);
      chk("miss_count", Miss_Count, m_mc);
      if (!em) chk("data", bus_out[31:0], data_of(a & ~32'h3));
    end
    if (rst) begin
      m_init = 1; m_v = '0; busy = 0; m_maddr = 0; m_mc = 0;
    end else begin
      if (inv) m_v = '0;
      if (!busy && em) begin
        busy = 1; m_base = lbase(a); m_maddr = m_base; m_acks = 0; m_mc++;
      end else if (busy && ack) begin
        m_acks++;
        if (m_acks == W) begin
          m_v[li(m_base)] = 1; m_b[li(m_base)] = m_base; busy = 0;
        end else m_maddr += 4;
      end
    end
  endtask

  task automatic fill(input logic [31:0] a);
    for (int i = 0; i <= W; i++) tick(0, a, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // 1: cold miss, one row per cycle
    v[0] = '{1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'd0, 32'h0,  1'b0};
    v[1] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   32'd0, 32'h0,  1'b0};
    v[2] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'd1, 32'h0,  1'b0};
    v[3] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 32'd1, 32'h0,  1'b0};
    v[4] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h108, 32'd1, 32'h0,  1'b0};
    v[5] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b1, 1'b1, 32'h10C, 32'd1, 32'h0,  1'b0};
    v[6] = '{1'b0, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10C, 32'd1, 32'hA0, 1'b1};
    v[7] = '{1'b0, 32'h10C, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10C, 32'd1, 32'hA3, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tick(v[i].rst, v[i].addr, 0, v[i].ack);
      if (v[i].chk) begin
        chk($sformatf("t1_imiss[%0d]", i), {31'd0, bus_out[32]}, {31'd0, v[i].imiss});
        chk($sformatf("t1_req[%0d]", i), {31'd0, Mem_Req}, {31'd0, v[i].req});
        chk($sformatf("t1_maddr[%0d]", i), Mem_Addr, v[i].maddr);
        chk($sformatf("t1_mc[%0d]", i), Miss_Count, v[i].mc);
        if (v[i].dchk) chk($sformatf("t1_data[%0d]", i), bus_out[31:0], v[i].data);
      end
    end
    // 2: stalled memory, three idle cycles before every ack
    tick(1, 32'h100, 0, 0);
    tick(0, 32'h100, 0, 0);
    for (int w = 0; w < W; w++) begin
      for (int s = 0; s < 3; s++) begin
        tick(0, 32'h100, 0, 0);
        chk("t2_hold_addr", Mem_Addr, 32'h100 + 32'(4 * w));
        chk("t2_imiss", {31'd0, bus_out[32]}, 32'd1);
      end
      tick(0, 32'h100, 0, 1);
    end
    for (int w = 0; w < W; w++) begin
      tick(0, 32'h100 + 32'(4 * w), 0, 0);
      chk("t2_hit", {31'd0, bus_out[32]}, 32'd0);
      chk("t2_word", bus_out[31:0], 32'hA0 + 32'(w));
    end
    // 3: conflict eviction on index 0
    fill(32'h200);
    tick(0, 32'h200, 0, 0);
    chk("t3_hit200", {31'd0, bus_out[32]}, 32'd0);
    tick(0, 32'h100, 0, 1);
    chk("t3_miss100", {31'd0, bus_out[32]}, 32'd1);
    tick(0, 32'h100, 0, 1);
    chk("t3_count", Miss_Count, 32'd3);
    for (int i = 0; i < W; i++) tick(0, 32'h100, 0, 1);
    // 4: redirect mid-refill does not abort the latched line
    tick(1, 32'h0, 0, 0);
    tick(0, 32'h100, 0, 1);
    tick(0, 32'h100, 0, 1);
    tick(0, 32'h100, 0, 1);
    for (int i = 0; i < 3; i++) tick(0, 32'h340, 0, 1);
    chk("t4_miss340", {31'd0, bus_out[32]}, 32'd1);
    tick(0, 32'h340, 0, 1);
    chk("t4_addr340", Mem_Addr, 32'h340);
    for (int i = 0; i < W - 1; i++) tick(0, 32'h340, 0, 1);
    tick(0, 32'h100, 0, 0);
    chk("t4_hit100", {31'd0, bus_out[32]}, 32'd0);
    // 5: invalidate in idle, then together with the last ack
    tick(1, 32'h0, 0, 0);
    fill(32'h100);
    fill(32'h110);
    tick(0, 32'h110, 1, 0);
    chk("t5_hit_before_inv", {31'd0, bus_out[32]}, 32'd0);
    tick(0, 32'h110, 0, 1);
    chk("t5_miss110", {31'd0, bus_out[32]}, 32'd1);
    for (int i = 0; i < W; i++) tick(0, 32'h110, 0, 1);
    tick(0, 32'h100, 0, 1);
    chk("t5_miss100", {31'd0, bus_out[32]}, 32'd1);
    for (int i = 0; i < W; i++) tick(0, 32'h100, 0, 1);
    tick(0, 32'h120, 0, 1);
    for (int i = 0; i < W - 1; i++) tick(0, 32'h120, 0, 1);
    tick(0, 32'h120, 1, 1);
    tick(0, 32'h120, 0, 0);
    chk("t5_hit120", {31'd0, bus_out[32]}, 32'd0);
    tick(0, 32'h100, 0, 0);
    chk("t5_miss100_after", {31'd0, bus_out[32]}, 32'd1);
    for (int i = 0; i < W; i++) tick(0, 32'h100, 0, 1);
    // 6: reset aborts a refill after two acks
    tick(1, 32'h0, 0, 0);
    tick(0, 32'h100, 0, 1);
    tick(0, 32'h100, 0, 1);
    tick(0, 32'h100, 0, 1);
    tick(1, 32'h100, 0, 1);
    tick(0, 32'h100, 0, 1);
    chk("t6_req", {31'd0, Mem_Req}, 32'd0);
    chk("t6_addr", Mem_Addr, 32'd0);
    chk("t6_count", Miss_Count, 32'd0);
    chk("t6_miss", {31'd0, bus_out[32]}, 32'd1);
    for (int i = 0; i < W; i++) tick(0, 32'h100, 0, 1);
    tick(0, 32'h104, 0, 0);
    chk("t6_hit", {31'd0, bus_out[32]}, 32'd0);
    chk("t6_word", bus_out[31:0], 32'hA1);
    // random traffic over a few conflicting lines plus the top of memory
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFF00 : 32'($urandom_range(0, 3)) << 8;
      a = a | (32'($urandom_range(0, 3)) << 4) | 32'($urandom_range(0, 15));
      tick($urandom_range(0, 199) == 0, a, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder that sits on the other end of the fetch-stage I-cache bus.
- Each cycle it receives the next fetch address and returns {Imiss, instruction} combinationally, so the fetch stage can latch the instruction on the same clock edge.
- It is a direct-mapped cache held in register arrays.
- On a miss it refills the whole line from instruction memory through a req/ack handshake, word by word, and holds Imiss high until the line is valid.

Parameters:
LINES, 16, number of cache lines (power of 2, ≥2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥2)

Ports:
Clk  input  1  clock, all state updates on rising edge
Rst  input  1  synchronous reset, active-high
Icache_bus_in  input  32  fetch address from the fetch stage (byte address; bits [1:0] ignored)
Icache_bus_out  output  33  [32]=Imiss, [31:0]=instruction word
Inv  input  1  invalidate all lines (synchronous)
Mem_Req  output  1  refill request to instruction memory, registered
Mem_Addr  output  32  word-aligned refill address, registered
Mem_Data  input  32  refill data, valid when Mem_Ack=1
Mem_Ack  input  1  memory accepts and returns one word this cycle
Miss_Count  output  32  count of refills started (performance counter)

Behaviour:
- Address split, with WB=log2(WORDS_PER_LINE) and IB=log2(LINES):
  - word offset = addr[2+WB-1:2]
  - index = addr[2+WB+IB-1:2+WB]
  - tag = the remaining upper bits
  - defaults: word [3:2], index [7:4], tag [31:8]
- Hit = valid[index] && tag_mem[index]==tag && state==IDLE.
- Icache_bus_out[32] = !hit, combinational.
- Icache_bus_out[31:0] = data_mem[index][word], combinational, regardless of hit. This value is don't-care when Imiss=1 and must not be relied on by the bench.
- FSM has two states, IDLE and REFILL.
- IDLE:
  - On a miss, latch line_base = {addr[31:2+WB], 0…} and the index.
  - Set Mem_Req<=1, Mem_Addr<=line_base, cnt<=0, Miss_Count<=Miss_Count+1.
  - Next state is REFILL.
- REFILL:
  - Imiss is forced to 1.
  - Mem_Req stays 1 and Mem_Addr stays stable until Mem_Ack.
  - On Mem_Ack, write data_mem[latched index][cnt]<=Mem_Data.
  - If cnt < WORDS_PER_LINE-1: cnt++ and Mem_Addr<=Mem_Addr+4.
  - Else (last word): tag_mem<=latched tag, valid<=1, Mem_Req<=0, next state IDLE.
  - Without Mem_Ack the FSM waits indefinitely.
- Latency:
  - With Mem_Ack tied high, a miss detected in cycle N gives REFILL in cycles N+1..N+WORDS_PER_LINE.
  - The line is valid at the edge ending cycle N+WORDS_PER_LINE.
  - Hit (Imiss=0) in cycle N+WORDS_PER_LINE+1 if the address is unchanged.
- A fetch address that changes during REFILL (flush or redirect) does not abort the refill. The latched line completes, then the new address is evaluated in IDLE.
- Mem_Addr wraps modulo 2^32; no special handling.
- Inv:
  - In IDLE, clears all valid bits at the edge.
  - In REFILL, clears all valid bits except that the line being refilled still becomes valid on its last ack.
  - Inv and the last ack in the same cycle: the refilled line ends valid and all others end invalid.
- Rst takes priority over everything: valid all 0, state IDLE, Mem_Req=0, Mem_Addr=0, cnt=0, Miss_Count=0.
- Rst during REFILL aborts the refill; the partially written line stays invalid.
- data_mem and tag_mem are not reset.
- Miss_Count wraps at 2^32.

Test Plan:
1. Cold miss:
   - Stimulus: Rst 1 cycle, addr=0x00000100, Mem_Ack=1 with Mem_Data=0xA0+cnt.
   - Required: Imiss=1 at once; Mem_Req=1 for 4 cycles with Mem_Addr 0x100, 0x104, 0x108, 0x10C.
   - Required, cycle 6: Imiss=0 and out[31:0]=0xA0; addr 0x10C then returns 0xA3, hit; Miss_Count=1.
2. Stalled memory:
   - Stimulus: as scenario 1, with Mem_Ack low for 3 cycles before each word.
   - Required: Mem_Addr is held at each word until its ack; Imiss stays 1 throughout; the final line contents are identical to scenario 1.
3. Conflict eviction:
   - Stimulus: fill 0x100, then fetch 0x200 (same index 0, tag 2).
   - Required: miss and refill; afterwards 0x200 hits and 0x100 misses again; Miss_Count=3.
4. Redirect during refill:
   - Stimulus: miss on 0x100; change addr to 0x340 mid-refill.
   - Required: refill of 0x100 completes; 0x340 then misses and is refilled from Mem_Addr 0x340; afterwards 0x100 hits.
5. Invalidate:
   - Stimulus: lines 0x100 and 0x110 valid; pulse Inv in IDLE.
   - Required: both miss next.
   - Stimulus: pulse Inv together with the last ack of a refill of 0x120.
   - Required: 0x120 hits and 0x100 misses.
6. Reset mid-refill:
   - Stimulus: assert Rst after 2 acks of 0x100.
   - Required: Mem_Req=0, Mem_Addr=0, Miss_Count=0 next cycle; 0x100 then misses and performs a full 4-word refill.
